matrix_display_arbiter: RTL

- Shares the single 8x8 LED matrix scanner between NUM_REQ game/demo modules.
- Round-robin arbitration with a bounded ownership time, so no single game can hold the display forever.
- Inserts a blank interval on every owner change.
- Holds a registered frame buffer that feeds the scanner's 64-bit grid input; only the current owner can update it.

---
 rtl/matrix_display_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/matrix_display_arbiter.sv
// Round-robin arbiter sharing one 8x8 LED matrix scanner between NUM_REQ sources.
// Blanks the display on every owner change and bounds ownership time when others wait.
module matrix_display_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int BLANK_CYCLES    = 16,
    parameter int MAX_HOLD_CYCLES = 50_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         frame_valid,
    input  logic [NUM_REQ*64-1:0]      grid_in,
    output logic [63:0]                grid_out,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] owner_id,
    output logic                       busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BW  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int HW  = $clog2(MAX_HOLD_CYCLES);

    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(MAX_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BLANK, OWN} state_t;

    state_t             state;
    logic [IDW-1:0]     last;
    logic [BW-1:0]      blank_cnt;
    logic [HW-1:0]      hold_cnt;

    logic [IDW-1:0]     pick;
    logic               pick_found;
    logic [NUM_REQ-1:0] owner_mask;
    logic [NUM_REQ-1:0] others;
    logic [63:0]        owner_slice;
    logic               owner_req;
    logic               hold_sat;

    // Search starts just after the last owner, so it is the lowest priority next time.
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        pick       = last;
        pick_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!pick_found && req[(int'(last) + k) % NUM_REQ]) begin
                pick       = IDW'((int'(last) + k) % NUM_REQ);
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        owner_mask  = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_id;
        others      = req & ~owner_mask;
        owner_slice = grid_in[64*int'(owner_id) +: 64];
        owner_req   = req[owner_id];
        hold_sat    = (hold_cnt == HOLD_LAST);
    end

    // owner_id doubles as the pending owner while in BLANK.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grid_out  <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            owner_id  <= '0;
            last      <= IDW'(NUM_REQ - 1);
            blank_cnt <= '0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    grant    <= '0;
                    grid_out <= '0;
                    busy     <= 1'b0;
                    if (|req) begin
                        owner_id  <= pick;
                        blank_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= BLANK;
                    end
                end

                BLANK: begin
                    if (blank_cnt == BLANK_LAST) begin
                        if (owner_req) begin
                            state    <= OWN;
                            grant    <= owner_mask;
                            grid_out <= owner_slice;
                            last     <= owner_id;
                            hold_cnt <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        blank_cnt <= blank_cnt + 1'b1;
                    end
                end

                OWN: begin
                    // Release wins over a same-cycle frame; preemption only when someone waits.
                    if (!owner_req || (hold_sat && |others)) begin
                        grant    <= '0;
                        grid_out <= '0;
                        if (|others) begin
                            owner_id  <= pick;
                            blank_cnt <= '0;
                            state     <= BLANK;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        if (!hold_sat)
                            hold_cnt <= hold_cnt + 1'b1;
                        if (frame_valid[owner_id])
                            grid_out <= owner_slice;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
